// File: rtl/sme_rng_sched_if.sv
// ----------------------------------------------------------------------------
// sme_rng_sched_if
//   Connects the SME RNG scheduler to its masking consumers.
//   master : the scheduler. It drives gnt, rng_update, rng_fresh and
//            grant_count, and it samples req.
//   slave  : the requester side. It drives req and observes everything else.
// Signals
//   req          NREQ  level requests, held by each requester until granted
//   gnt          NREQ  one-hot grant, asserted for a single cycle
//   rng_update   1     RNG update / clock request strobe
//   rng_fresh    1     RNG outputs are fresh and unconsumed
//   grant_count  16    wrapping count of grants issued
// ----------------------------------------------------------------------------
interface sme_rng_sched_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic            rng_update;
   logic            rng_fresh;
   logic [15:0]     grant_count;

   modport master (
      input  req,
      output gnt,
      output rng_update,
      output rng_fresh,
      output grant_count
   );

   modport slave (
      output req,
      input  gnt,
      input  rng_update,
      input  rng_fresh,
      input  grant_count
   );
endinterface

// File: rtl/sme_rng_sched.sv
// ----------------------------------------------------------------------------
// sme_rng_sched
//   Shares one set of RNG guard-share outputs among NREQ masking consumers.
//   Each grant sees randomness that no other requester has seen. After every
//   grant, and after RESEED_PERIOD idle READY cycles, the RNG is clocked for
//   WARMUP cycles before it can issue another grant.
// Ports
//   g_clk     clock
//   g_reset   asynchronous active-high reset; the FSM returns to INIT
//   trng_rdy  TRNG ready gate. This port exists only when the macro
//             SME_RNG_SCHED_TRNG_GATE_EN is defined.
//   bus       sme_rng_sched_if.master (req, gnt, rng_update, rng_fresh,
//             grant_count)
// Configuration
//   SME_RNG_SCHED_TRNG_GATE_EN : when defined, WARM leaves for READY only
//   while trng_rdy is high. When undefined, WARM exit depends only on the
//   warm-up counter.
// ----------------------------------------------------------------------------
module sme_rng_sched #(
   parameter int NREQ          = 4,
   parameter int WARMUP        = 2,
   parameter int RESEED_PERIOD = 16
) (
   input  logic                  g_clk,
   input  logic                  g_reset,
`ifdef SME_RNG_SCHED_TRNG_GATE_EN
   input  logic                  trng_rdy,
`endif
   sme_rng_sched_if.master       bus
);

   localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W  = $clog2(WARMUP + 1);
   localparam int IDLE_W = (RESEED_PERIOD > 1) ? $clog2(RESEED_PERIOD) : 1;

   localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NREQ - 1);
   localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(WARMUP);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((RESEED_PERIOD > 0) ? RESEED_PERIOD - 1 : 0);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_WARM  = 2'd1,
      S_READY = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [IDLE_W-1:0]  idle_q;
   logic [15:0]        grant_count_q;
   logic               rng_update_q;
   logic               rng_fresh_q;

   logic               trng_ok;
   logic [PTR_W-1:0]   win;
   logic               win_vld;
   logic [PTR_W-1:0]   ptr_next;
   logic [NREQ-1:0]    gnt_vec;

`ifdef SME_RNG_SCHED_TRNG_GATE_EN
   assign trng_ok = trng_rdy;
`else
   assign trng_ok = 1'b1;
`endif

   // Round-robin search. The winner is the first requester at or after
   // ptr_q, wrapping around. Requesters that are not asking are skipped.
   always_comb begin
      int idx;
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!win_vld && bus.req[idx]) begin
            win_vld = 1'b1;
            win     = PTR_W'(idx);
         end
      end
   end

   assign ptr_next = (win == PTR_LAST) ? '0 : win + 1'b1;

   // The grant is Mealy on req. The consumer uses the RNG outputs in the
   // same cycle it sees gnt, so the grant cannot wait for a register.
   always_comb begin
      gnt_vec = '0;
      if (state_q == S_READY && win_vld) gnt_vec[win] = 1'b1;
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state_q       <= S_INIT;
         cnt_q         <= '0;
         ptr_q         <= '0;
         idle_q        <= '0;
         grant_count_q <= '0;
         rng_update_q  <= 1'b0;
         rng_fresh_q   <= 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               state_q      <= S_WARM;
               cnt_q        <= CNT_INIT;
               rng_update_q <= 1'b1;
               rng_fresh_q  <= 1'b0;
            end
            S_WARM: begin
               // The counter holds at 1 until the TRNG gate opens, and the
               // RNG keeps being clocked while it waits.
               if (cnt_q == CNT_ONE) begin
                  if (trng_ok) begin
                     state_q      <= S_READY;
                     rng_update_q <= 1'b0;
                     rng_fresh_q  <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_READY: begin
               // A grant takes priority over reseed expiry in the same cycle.
               if (win_vld) begin
                  ptr_q         <= ptr_next;
                  grant_count_q <= grant_count_q + 16'd1;
                  idle_q        <= '0;
                  state_q       <= S_WARM;
                  cnt_q         <= CNT_INIT;
                  rng_update_q  <= 1'b1;
                  rng_fresh_q   <= 1'b0;
               end else if (RESEED_PERIOD != 0 && idle_q == IDLE_LAST) begin
                  idle_q       <= '0;
                  state_q      <= S_WARM;
                  cnt_q        <= CNT_INIT;
                  rng_update_q <= 1'b1;
                  rng_fresh_q  <= 1'b0;
               end else begin
                  idle_q <= idle_q + 1'b1;
               end
            end
            default: begin
               state_q      <= S_INIT;
               rng_update_q <= 1'b0;
               rng_fresh_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt         = gnt_vec;
   assign bus.rng_update  = rng_update_q;
   assign bus.rng_fresh   = rng_fresh_q;
   assign bus.grant_count = grant_count_q;

endmodule

// File: tb/tb_sme_rng_sched.sv
// ----------------------------------------------------------------------------
// tb_sme_rng_sched
//   Directed bench for sme_rng_sched with NREQ=4, WARMUP=2, RESEED_PERIOD=8.
//   A per-cycle vector table covers warm-up, round-robin, skip/wrap and idle
//   reseed. Hand-written sequences cover counter wrap and reset during WARM.
// ----------------------------------------------------------------------------
module tb_sme_rng_sched;

   logic g_clk;
   logic g_reset;
`ifdef SME_RNG_SCHED_TRNG_GATE_EN
   logic trng_rdy;
`endif

   sme_rng_sched_if #(.NREQ(4)) bus ();

   sme_rng_sched #(
      .NREQ          (4),
      .WARMUP        (2),
      .RESEED_PERIOD (8)
   ) dut (
      .g_clk    (g_clk),
      .g_reset  (g_reset),
`ifdef SME_RNG_SCHED_TRNG_GATE_EN
      .trng_rdy (trng_rdy),
`endif
      .bus      (bus)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  gnt;
      logic        upd;
      logic        fresh;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic u,
                          input logic f, input logic [15:0] c);
      chk({tag, "_gnt"},   32'(bus.gnt), 32'(g));
      chk({tag, "_upd"},   32'(bus.rng_update), 32'(u));
      chk({tag, "_fresh"}, 32'(bus.rng_fresh), 32'(f));
      chk({tag, "_count"}, 32'(bus.grant_count), 32'(c));
      chk({tag, "_excl"},  32'(bus.rng_update && (bus.gnt != 4'b0000)), 32'd0);
      chk({tag, "_onehot"}, 32'($onehot0(bus.gnt)), 32'd1);
   endtask

   // Apply a req right after the rising edge. Outputs are then sampled
   // mid-cycle, once the Mealy grant path has settled.
   task automatic tick(input logic [3:0] r);
      @(posedge g_clk);
      #1 bus.req = r;
      #1;
   endtask

   task automatic add(input logic [3:0] r, input logic [3:0] g, input logic u,
                      input logic f, input logic [15:0] c);
      vec_t v;
      v.req = r; v.gnt = g; v.upd = u; v.fresh = f; v.cnt = c;
      tbl.push_back(v);
   endtask

   task automatic add_warm(input logic [3:0] r, input logic [15:0] c);
      add(r, 4'b0000, 1'b1, 1'b0, c);
      add(r, 4'b0000, 1'b1, 1'b0, c);
   endtask

   task automatic add_idle(input int n, input logic [15:0] c);
      for (int k = 0; k < n; k++) add(4'b0000, 4'b0000, 1'b0, 1'b1, c);
   endtask

   initial begin
      // Each entry is one cycle, beginning with the first edge after reset
      // is released.
      add_warm(4'b1111, 16'd0);
      add(4'b1111, 4'b0001, 1'b0, 1'b1, 16'd0); add_warm(4'b1111, 16'd1);
      add(4'b1111, 4'b0010, 1'b0, 1'b1, 16'd1); add_warm(4'b1111, 16'd2);
      add(4'b1111, 4'b0100, 1'b0, 1'b1, 16'd2); add_warm(4'b1111, 16'd3);
      add(4'b1111, 4'b1000, 1'b0, 1'b1, 16'd3); add_warm(4'b1111, 16'd4);
      add(4'b1111, 4'b0001, 1'b0, 1'b1, 16'd4); add_warm(4'b0100, 16'd5);
      // Grant requester 2 so that ptr becomes 3 before the skip/wrap check.
      add(4'b0100, 4'b0100, 1'b0, 1'b1, 16'd5); add_warm(4'b0101, 16'd6);
      add(4'b0101, 4'b0001, 1'b0, 1'b1, 16'd6); add_warm(4'b0100, 16'd7);
      add(4'b0100, 4'b0100, 1'b0, 1'b1, 16'd7); add_warm(4'b0000, 16'd8);
      // Eight idle READY cycles, then a forced refresh with no grant.
      add_idle(8, 16'd8);
      add_warm(4'b0000, 16'd8);
      // A request on the eighth idle cycle wins over the reseed.
      add_idle(7, 16'd8);
      add(4'b0010, 4'b0010, 1'b0, 1'b1, 16'd8);
      add_warm(4'b0000, 16'd9);
      add_idle(2, 16'd9);

      bus.req = 4'b0000;
`ifdef SME_RNG_SCHED_TRNG_GATE_EN
      trng_rdy = 1'b1;
`endif
      g_reset = 1'b1;
      repeat (3) @(posedge g_clk);
      #1 chk_out("in_reset", 4'b0000, 1'b0, 1'b0, 16'd0);
      g_reset = 1'b0;
      #1 chk_out("init", 4'b0000, 1'b0, 1'b0, 16'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         tick(tbl[i].req);
         chk_out($sformatf("v%0d", i), tbl[i].gnt, tbl[i].upd, tbl[i].fresh, tbl[i].cnt);
      end

      // Counter wrap. Preload the count at 0xFFFF while idle, then issue
      // one grant. ptr is 2 here, so requester 0 wins by wrapping.
      force dut.grant_count_q = 16'hFFFF;
      #1 release dut.grant_count_q;
      #1 chk("wrap_preload", 32'(bus.grant_count), 32'h0000FFFF);
      tick(4'b0001);
      chk_out("wrap_gnt", 4'b0001, 1'b0, 1'b1, 16'hFFFF);
      tick(4'b0000);
      chk_out("wrap_w0", 4'b0000, 1'b1, 1'b0, 16'h0000);
      tick(4'b1111);
      chk_out("wrap_w1", 4'b0000, 1'b1, 1'b0, 16'h0000);

      // Reset in the middle of WARM: every output clears at once, without
      // waiting for a clock edge.
      #1 g_reset = 1'b1;
      #1 chk_out("rst_async", 4'b0000, 1'b0, 1'b0, 16'd0);
      tick(4'b1111);
      chk_out("rst_hold", 4'b0000, 1'b0, 1'b0, 16'd0);
      g_reset = 1'b0;
      #1 chk_out("rst_init", 4'b0000, 1'b0, 1'b0, 16'd0);
      tick(4'b1111);
      chk_out("rst_w0", 4'b0000, 1'b1, 1'b0, 16'd0);
      tick(4'b1111);
      chk_out("rst_w1", 4'b0000, 1'b1, 1'b0, 16'd0);
      tick(4'b1111);
      chk_out("rst_ready", 4'b0001, 1'b0, 1'b1, 16'd0);
      tick(4'b0000);
      chk_out("rst_after", 4'b0000, 1'b1, 1'b0, 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
